// File: rtl/btn_pkg.sv
// Shared types and default timing for the multi-channel button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLDING,
        LONG
    } hold_state_e;

    localparam int CLK_HZ = 100_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce filter, hold FSM, auto-repeat.
// Auto-repeat is built only when BTN_DEBOUNCER_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB        = 4,
    parameter int HOLD       = 10,
    parameter int REP        = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DW = $clog2(DEB);
    localparam int HW = $clog2(HOLD);

    if (DEB < 2 || HOLD < 2 || REP < 2) begin : g_cfg_chk
        $error("btn_debounce_ch: timing parameters must be >= 2");
    end

    logic          s0_q, s1_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    hold_state_e   st_q, st_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s1_q != level_q) begin
            if (cnt_q == DW'(DEB - 1)) begin
                level_d = s1_q;
                press_d = s1_q;
                rel_d   = !s1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Long fires on the HOLD-th cycle of the accepted pressed level.
    always_comb begin
        st_d   = st_q;
        hcnt_d = hcnt_q;
        long_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (press_d) begin
                    st_d   = HOLDING;
                    hcnt_d = '0;
                end
            end
            HOLDING: begin
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_d == HW'(HOLD - 1)) begin
                    long_d = 1'b1;
                    st_d   = LONG;
                end
            end
            LONG: ;
            default: st_d = IDLE;
        endcase
        if (rel_d) begin
            st_d   = IDLE;
            hcnt_d = '0;
            long_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            st_q    <= IDLE;
            hcnt_q  <= '0;
        end else begin
            s0_q    <= btn_i ^ ACTIVE_LOW;
            s1_q    <= s0_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            st_q    <= st_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;

`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
    localparam int RW = $clog2(REP);

    logic [RW-1:0] rep_q, rep_d;
    logic          rpt_q, rpt_d;

    always_comb begin
        rep_d = '0;
        rpt_d = 1'b0;
        if (st_q == LONG && st_d == LONG) begin
            if (rep_q == RW'(REP - 1)) begin
                rpt_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_q <= '0;
            rpt_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
            rpt_q <= rpt_d;
        end
    end

    assign repeat_o = rpt_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer_multi.sv
// N-channel button conditioner with one-cycle press/release/long/repeat events.
// Optional auto-repeat: define BTN_DEBOUNCER_AUTOREPEAT_EN.
module btn_debouncer_multi
    import btn_pkg::*;
#(
    parameter int NUM_CH          = 5,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int HOLD_CYCLES     = ms_to_cycles(500),
    parameter int REPEAT_CYCLES   = ms_to_cycles(100),
    parameter int ACTIVE_LOW      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_long,
    output logic [NUM_CH-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB        (DEBOUNCE_CYCLES),
            .HOLD       (HOLD_CYCLES),
            .REP        (REPEAT_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW != 0)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_i      (btn_in[i]),
            .level_o    (btn_level[i]),
            .press_o    (btn_press[i]),
            .release_o  (btn_release[i]),
            .long_o     (btn_long[i]),
            .repeat_o   (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_btn_debouncer_multi.sv
// Directed bench: active-high and active-low instances, D=4 H=10 R=3.
`timescale 1ns/1ps
module tb_btn_debouncer_multi;

    localparam int N = 3;

`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in, btn_in_al;
    logic [N-1:0] lvl, prs, rel, lng, rpt;
    logic [N-1:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_debouncer_multi #(
        .NUM_CH(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel),
        .btn_long(lng), .btn_repeat(rpt)
    );

    btn_debouncer_multi #(
        .NUM_CH(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .reset(reset), .btn_in(btn_in_al),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a),
        .btn_long(lng_a), .btn_repeat(rpt_a)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v);
        btn_in    = v;
        btn_in_al = ~v;
    endtask

    task automatic chk(input string tag, input int k,
                       input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive('0);
        repeat (3) step();
        chk("rst_lvl", 0, lvl, '0);
        chk("rst_prs", 0, prs, '0);
        chk("rst_rel", 0, rel, '0);
        chk("rst_lng", 0, lng, '0);
        chk("rst_rpt", 0, rpt, '0);
        chk("rst_lvl_al", 0, lvl_a, '0);
        chk("rst_prs_al", 0, prs_a, '0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_lvl", k, lvl, '0);
            chk("idle_prs", k, prs | rel, '0);
            chk("idle_lvl_al", k, lvl_a, '0);
        end

        // clean press and release on ch0
        drive(3'b001);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t1_lvl", k, lvl, (k >= 5) ? 3'b001 : 3'b000);
            chk("t1_prs", k, prs, (k == 5) ? 3'b001 : 3'b000);
            chk("t1_lvl_al", k, lvl_a, (k >= 5) ? 3'b001 : 3'b000);
            chk("t1_prs_al", k, prs_a, (k == 5) ? 3'b001 : 3'b000);
        end
        drive(3'b000);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t1r_lvl", k, lvl, (k < 5) ? 3'b001 : 3'b000);
            chk("t1r_rel", k, rel, (k == 5) ? 3'b001 : 3'b000);
            chk("t1r_prs", k, prs, 3'b000);
            chk("t1r_lng", k, lng, 3'b000);
            chk("t1r_rel_al", k, rel_a, (k == 5) ? 3'b001 : 3'b000);
        end

        // bounce on ch1: 3 high, 1 low, never stable long enough
        for (int r = 0; r < 3; r++) begin
            drive(3'b010);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("t2_lvl", k, lvl, 3'b000);
                chk("t2_prs", k, prs, 3'b000);
            end
            drive(3'b000);
            step();
            chk("t2_lvl", 3, lvl, 3'b000);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2s_lvl", k, lvl, 3'b000);
            chk("t2s_prs", k, prs | rel, 3'b000);
        end

        // long hold on ch2 with optional repeats
        drive(3'b100);
        for (int k = 0; k <= 25; k++) begin
            step();
            chk("t3_lvl", k, lvl, (k >= 5) ? 3'b100 : 3'b000);
            chk("t3_prs", k, prs, (k == 5) ? 3'b100 : 3'b000);
            chk("t3_lng", k, lng, (k == 14) ? 3'b100 : 3'b000);
            chk("t3_rpt", k, rpt,
                (RPT_EN && k >= 17 && (k - 14) % 3 == 0) ? 3'b100 : 3'b000);
        end
        drive(3'b000);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t3r_lvl", k, lvl, (k < 5) ? 3'b100 : 3'b000);
            chk("t3r_rel", k, rel, (k == 5) ? 3'b100 : 3'b000);
            chk("t3r_lng", k, lng, 3'b000);
            chk("t3r_rpt", k, rpt,
                (RPT_EN && (k == 0 || k == 3)) ? 3'b100 : 3'b000);
        end

        // short hold on ch2: level high 7 cycles, no long
        drive(3'b100);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t4_lvl", k, lvl, (k >= 5) ? 3'b100 : 3'b000);
            chk("t4_lng", k, lng, 3'b000);
        end
        drive(3'b000);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t4r_lvl", k, lvl, (k < 5) ? 3'b100 : 3'b000);
            chk("t4r_rel", k, rel, (k == 5) ? 3'b100 : 3'b000);
            chk("t4r_lng", k, lng, 3'b000);
        end
        drive(3'b100);
        for (int k = 0; k <= 15; k++) begin
            step();
            chk("t4p_prs", k, prs, (k == 5) ? 3'b100 : 3'b000);
            chk("t4p_lng", k, lng, (k == 14) ? 3'b100 : 3'b000);
        end
        drive(3'b000);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t4q_rel", k, rel, (k == 5) ? 3'b100 : 3'b000);
        end

        // simultaneous press/release on all channels
        drive(3'b111);
        for (int k = 0; k <= 5; k++) begin
            step();
            chk("t5_prs", k, prs, (k == 5) ? 3'b111 : 3'b000);
            chk("t5_lvl", k, lvl, (k == 5) ? 3'b111 : 3'b000);
            chk("t5_prs_al", k, prs_a, (k == 5) ? 3'b111 : 3'b000);
        end
        drive(3'b000);
        for (int k = 0; k <= 6; k++) begin
            step();
            chk("t5r_rel", k, rel, (k == 5) ? 3'b111 : 3'b000);
            chk("t5r_prs", k, prs, 3'b000);
            chk("t5r_rel_al", k, rel_a, (k == 5) ? 3'b111 : 3'b000);
        end

        // reset mid-hold (ch2) and mid-debounce (ch0)
        drive(3'b100);
        repeat (8) step();
        chk("t6_pre_lvl", 0, lvl, 3'b100);
        drive(3'b101);
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("t6_rst_lvl", 0, lvl, 3'b000);
        chk("t6_rst_ev", 0, prs | rel | lng | rpt, 3'b000);
        chk("t6_rst_lvl_al", 0, lvl_a, 3'b000);
        step();
        reset = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            step();
            chk("t6_lvl", k, lvl, (k >= 5) ? 3'b101 : 3'b000);
            chk("t6_prs", k, prs, (k == 5) ? 3'b101 : 3'b000);
            chk("t6_rel", k, rel, 3'b000);
            chk("t6_lng", k, lng, (k == 14) ? 3'b101 : 3'b000);
        end
        drive(3'b000);
        repeat (7) step();
        chk("t6_end_lvl", 0, lvl, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
